// File: rtl/alu_decode_stage.sv
// ID/EX stage: decodes an RV32I instruction into ALU control, flag select, immediate
// and datapath selects, registered once behind a valid/ready handshake with flush.
module alu_decode_stage #(
    parameter int XLEN = 32
) (
    input  logic            Clk_i,
    input  logic            Rst_ni,
    input  logic [31:0]     Instr_i,
    input  logic [XLEN-1:0] Pc_i,
    input  logic            InstrValid_i,
    output logic            InstrReady_o,
    input  logic            Flush_i,
    input  logic            Ready_i,
    output logic            Valid_o,
    output logic [3:0]      ALUCtrl_o,
    output logic [2:0]      Flagsel_o,
    output logic [XLEN-1:0] Imm_o,
    output logic            SrcASel_o,
    output logic            SrcBSel_o,
    output logic [4:0]      Rs1_o,
    output logic [4:0]      Rs2_o,
    output logic [4:0]      Rd_o,
    output logic [XLEN-1:0] Pc_o,
    output logic            RegWrite_o,
    output logic            MemRead_o,
    output logic            MemWrite_o,
    output logic            Branch_o,
    output logic            Jump_o,
    output logic            SetFlag_o,
    output logic            Illegal_o
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [3:0] ALU_ADD = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_SLL = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SRL = 4'b0100;
    localparam logic [3:0] ALU_SRA = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0111;
    localparam logic [3:0] ALU_LUI = 4'b1000;

    logic [6:0]      w_opcode;
    logic [2:0]      w_f3;
    logic [6:0]      w_f7;
    logic            w_f7_zero;
    logic            w_f7_alt;
    logic            w_is_imm;
    logic [XLEN-1:0] w_imm_i, w_imm_s, w_imm_b, w_imm_j, w_imm_sh, w_imm_lui, w_imm_auipc;

    assign w_opcode  = Instr_i[6:0];
    assign w_f3      = Instr_i[14:12];
    assign w_f7      = Instr_i[31:25];
    assign w_f7_zero = (w_f7 == 7'b0000000);
    assign w_f7_alt  = (w_f7 == 7'b0100000);
    assign w_is_imm  = (w_opcode == OPC_OPIMM);

    assign w_imm_i     = {{20{Instr_i[31]}}, Instr_i[31:20]};
    assign w_imm_s     = {{20{Instr_i[31]}}, Instr_i[31:25], Instr_i[11:7]};
    assign w_imm_b     = {{20{Instr_i[31]}}, Instr_i[7], Instr_i[30:25], Instr_i[11:8], 1'b0};
    assign w_imm_j     = {{12{Instr_i[31]}}, Instr_i[19:12], Instr_i[20], Instr_i[30:21], 1'b0};
    assign w_imm_sh    = {27'b0, Instr_i[24:20]};
    assign w_imm_lui   = {12'b0, Instr_i[31:12]};
    assign w_imm_auipc = {Instr_i[31:12], 12'b0};

    logic [3:0]      w_alu;
    logic [2:0]      w_flag;
    logic [XLEN-1:0] w_imm;
    logic            w_srca, w_srcb, w_regw, w_mrd, w_mwr, w_br, w_jmp, w_setf, w_ill;

    always_comb begin
        w_alu  = ALU_ADD;
        w_flag = 3'b000;
        w_imm  = '0;
        w_srca = 1'b0;
        w_srcb = 1'b0;
        w_regw = 1'b0;
        w_mrd  = 1'b0;
        w_mwr  = 1'b0;
        w_br   = 1'b0;
        w_jmp  = 1'b0;
        w_setf = 1'b0;
        w_ill  = 1'b0;
        case (w_opcode)
            // Register and immediate ALU forms share one mapping; funct7 only matters
            // for the register form and for the immediate shifts.
            OPC_OP, OPC_OPIMM: begin
                w_regw = 1'b1;
                w_srcb = w_is_imm;
                w_imm  = w_is_imm ? w_imm_i : '0;
                case (w_f3)
                    3'b000: begin
                        w_alu = (!w_is_imm && w_f7_alt) ? ALU_SUB : ALU_ADD;
                        w_ill = !w_is_imm && !(w_f7_zero || w_f7_alt);
                    end
                    3'b001: begin
                        w_alu = ALU_SLL;
                        w_ill = !w_f7_zero;
                        if (w_is_imm) w_imm = w_imm_sh;
                    end
                    3'b010: begin
                        w_alu  = ALU_SUB;
                        w_flag = 3'b100;
                        w_setf = 1'b1;
                        w_ill  = !w_is_imm && !w_f7_zero;
                    end
                    3'b011: begin
                        w_alu  = ALU_SUB;
                        w_flag = 3'b110;
                        w_setf = 1'b1;
                        w_ill  = !w_is_imm && !w_f7_zero;
                    end
                    3'b100: begin
                        w_alu = ALU_XOR;
                        w_ill = !w_is_imm && !w_f7_zero;
                    end
                    3'b101: begin
                        w_alu = w_f7[5] ? ALU_SRA : ALU_SRL;
                        w_ill = !(w_f7_zero || w_f7_alt);
                        if (w_is_imm) w_imm = w_imm_sh;
                    end
                    3'b110: begin
                        w_alu = ALU_OR;
                        w_ill = !w_is_imm && !w_f7_zero;
                    end
                    default: begin
                        w_alu = ALU_AND;
                        w_ill = !w_is_imm && !w_f7_zero;
                    end
                endcase
            end
            OPC_LUI: begin
                w_alu  = ALU_LUI;
                w_imm  = w_imm_lui;
                w_srcb = 1'b1;
                w_regw = 1'b1;
            end
            OPC_AUIPC: begin
                w_imm  = w_imm_auipc;
                w_srca = 1'b1;
                w_srcb = 1'b1;
                w_regw = 1'b1;
            end
            OPC_LOAD: begin
                w_imm  = w_imm_i;
                w_srcb = 1'b1;
                w_mrd  = 1'b1;
                w_regw = 1'b1;
                w_ill  = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
            end
            OPC_STORE: begin
                w_imm  = w_imm_s;
                w_srcb = 1'b1;
                w_mwr  = 1'b1;
                w_ill  = w_f3[2] || (w_f3 == 3'b011);
            end
            OPC_BRANCH: begin
                w_alu  = ALU_SUB;
                w_flag = w_f3;
                w_imm  = w_imm_b;
                w_br   = 1'b1;
                w_ill  = (w_f3 == 3'b010) || (w_f3 == 3'b011);
            end
            OPC_JAL: begin
                w_imm  = w_imm_j;
                w_srca = 1'b1;
                w_srcb = 1'b1;
                w_jmp  = 1'b1;
                w_regw = 1'b1;
            end
            OPC_JALR: begin
                w_imm  = w_imm_i;
                w_srcb = 1'b1;
                w_jmp  = 1'b1;
                w_regw = 1'b1;
                w_ill  = (w_f3 != 3'b000);
            end
            default: w_ill = 1'b1;
        endcase
        // An illegal instruction still flows down the pipe, but with every
        // side-effecting strobe and operand select neutralised.
        if (w_ill) begin
            w_alu  = ALU_ADD;
            w_flag = 3'b000;
            w_imm  = '0;
            w_srca = 1'b0;
            w_srcb = 1'b0;
            w_regw = 1'b0;
            w_mrd  = 1'b0;
            w_mwr  = 1'b0;
            w_br   = 1'b0;
            w_jmp  = 1'b0;
            w_setf = 1'b0;
        end
    end

    logic w_instr_ready;
    logic w_load;

    assign w_instr_ready = !Valid_o || Ready_i;
    assign w_load        = InstrValid_i && w_instr_ready && !Flush_i;
    assign InstrReady_o  = w_instr_ready;

    always_ff @(posedge Clk_i or negedge Rst_ni) begin
        if (!Rst_ni) begin
            Valid_o    <= 1'b0;
            ALUCtrl_o  <= '0;
            Flagsel_o  <= '0;
            Imm_o      <= '0;
            SrcASel_o  <= 1'b0;
            SrcBSel_o  <= 1'b0;
            Rs1_o      <= '0;
            Rs2_o      <= '0;
            Rd_o       <= '0;
            Pc_o       <= '0;
            RegWrite_o <= 1'b0;
            MemRead_o  <= 1'b0;
            MemWrite_o <= 1'b0;
            Branch_o   <= 1'b0;
            Jump_o     <= 1'b0;
            SetFlag_o  <= 1'b0;
            Illegal_o  <= 1'b0;
        end else begin
            if (Flush_i)      Valid_o <= 1'b0;
            else if (w_load)  Valid_o <= 1'b1;
            else if (Ready_i) Valid_o <= 1'b0;
            if (w_load) begin
                ALUCtrl_o  <= w_alu;
                Flagsel_o  <= w_flag;
                Imm_o      <= w_imm;
                SrcASel_o  <= w_srca;
                SrcBSel_o  <= w_srcb;
                Rs1_o      <= Instr_i[19:15];
                Rs2_o      <= Instr_i[24:20];
                Rd_o       <= Instr_i[11:7];
                Pc_o       <= Pc_i;
                RegWrite_o <= w_regw;
                MemRead_o  <= w_mrd;
                MemWrite_o <= w_mwr;
                Branch_o   <= w_br;
                Jump_o     <= w_jmp;
                SetFlag_o  <= w_setf;
                Illegal_o  <= w_ill;
            end
        end
    end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Randomised scoreboard bench for alu_decode_stage: a mnemonic-level reference model
// predicts each accepted instruction; a monitor compares whatever the stage presents.
module tb_alu_decode_stage;

    typedef struct packed {
        logic [3:0]  alu;
        logic [2:0]  flag;
        logic [31:0] imm;
        logic        srca;
        logic        srcb;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] pc;
        logic        regw;
        logic        mrd;
        logic        mwr;
        logic        br;
        logic        jmp;
        logic        setf;
        logic        ill;
    } dec_t;

    typedef enum {
        K_ADD, K_SUB, K_SLL, K_SLT, K_SLTU, K_XOR, K_SRL, K_SRA, K_OR, K_AND,
        K_LUI, K_AUIPC, K_LOAD, K_STORE, K_BR, K_JAL, K_JALR, K_ILL
    } kind_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        in_valid = 1'b0;
    logic        in_ready = 1'b0;
    logic        in_flush = 1'b0;

    logic        InstrReady_o, Valid_o;
    logic [3:0]  ALUCtrl_o;
    logic [2:0]  Flagsel_o;
    logic [31:0] Imm_o, Pc_o;
    logic        SrcASel_o, SrcBSel_o;
    logic [4:0]  Rs1_o, Rs2_o, Rd_o;
    logic        RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, SetFlag_o, Illegal_o;

    int   n_checks = 0;
    int   n_errors = 0;
    dec_t exp_q[$];
    logic m_valid = 1'b0;

    alu_decode_stage #(.XLEN(32)) dut (
        .Clk_i(clk), .Rst_ni(rst_n), .Instr_i(in_instr), .Pc_i(in_pc),
        .InstrValid_i(in_valid), .InstrReady_o(InstrReady_o), .Flush_i(in_flush),
        .Ready_i(in_ready), .Valid_o(Valid_o), .ALUCtrl_o(ALUCtrl_o), .Flagsel_o(Flagsel_o),
        .Imm_o(Imm_o), .SrcASel_o(SrcASel_o), .SrcBSel_o(SrcBSel_o), .Rs1_o(Rs1_o),
        .Rs2_o(Rs2_o), .Rd_o(Rd_o), .Pc_o(Pc_o), .RegWrite_o(RegWrite_o),
        .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o), .Branch_o(Branch_o),
        .Jump_o(Jump_o), .SetFlag_o(SetFlag_o), .Illegal_o(Illegal_o)
    );

    always #5 clk = ~clk;

    function automatic dec_t dut_out();
        dec_t d;
        d = {ALUCtrl_o, Flagsel_o, Imm_o, SrcASel_o, SrcBSel_o, Rs1_o, Rs2_o, Rd_o, Pc_o,
             RegWrite_o, MemRead_o, MemWrite_o, Branch_o, Jump_o, SetFlag_o, Illegal_o};
        return d;
    endfunction

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Name the instruction as an assembler would, then derive fields per mnemonic.
    function automatic void classify(input logic [31:0] ins, output kind_t k, output logic imm_form);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = ins[14:12];
        f7 = ins[31:25];
        imm_form = 1'b0;
        k = K_ILL;
        case (ins[6:0])
            7'b0110011: begin
                case ({f7, f3})
                    10'b0000000_000: k = K_ADD;
                    10'b0100000_000: k = K_SUB;
                    10'b0000000_001: k = K_SLL;
                    10'b0000000_010: k = K_SLT;
                    10'b0000000_011: k = K_SLTU;
                    10'b0000000_100: k = K_XOR;
                    10'b0000000_101: k = K_SRL;
                    10'b0100000_101: k = K_SRA;
                    10'b0000000_110: k = K_OR;
                    10'b0000000_111: k = K_AND;
                    default:         k = K_ILL;
                endcase
            end
            7'b0010011: begin
                imm_form = 1'b1;
                case (f3)
                    3'd0: k = K_ADD;
                    3'd1: k = (f7 == 7'h00) ? K_SLL : K_ILL;
                    3'd2: k = K_SLT;
                    3'd3: k = K_SLTU;
                    3'd4: k = K_XOR;
                    3'd5: k = (f7 == 7'h00) ? K_SRL : ((f7 == 7'h20) ? K_SRA : K_ILL);
                    3'd6: k = K_OR;
                    default: k = K_AND;
                endcase
            end
            7'b0110111: k = K_LUI;
            7'b0010111: k = K_AUIPC;
            7'b0000011: k = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) ? K_LOAD : K_ILL;
            7'b0100011: k = (f3 inside {3'd0, 3'd1, 3'd2}) ? K_STORE : K_ILL;
            7'b1100011: k = (f3 inside {3'd2, 3'd3}) ? K_ILL : K_BR;
            7'b1101111: k = K_JAL;
            7'b1100111: k = (f3 == 3'd0) ? K_JALR : K_ILL;
            default:    k = K_ILL;
        endcase
    endfunction

    function automatic dec_t model(input logic [31:0] ins, input logic [31:0] pc);
        dec_t  d;
        kind_t k;
        logic  imm_form;
        int    imm_i, imm_s, imm_b, imm_j;
        imm_i = $signed(ins) >>> 20;
        imm_s = (($signed(ins) >>> 25) * 32) + int'(ins[11:7]);
        imm_b = (($signed(ins) >>> 31) * 4096) + int'(ins[7]) * 2048
              + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
        imm_j = (($signed(ins) >>> 31) * 1048576) + int'(ins[19:12]) * 4096
              + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
        classify(ins, k, imm_form);
        d = '0;
        d.rs1 = ins[19:15];
        d.rs2 = ins[24:20];
        d.rd  = ins[11:7];
        d.pc  = pc;
        case (k)
            K_ILL:   d.ill = 1'b1;
            K_LUI:   begin d.alu = 4'd8; d.imm = ins >> 12; d.srcb = 1'b1; d.regw = 1'b1; end
            K_AUIPC: begin d.imm = ins & 32'hFFFF_F000; d.srca = 1'b1; d.srcb = 1'b1; d.regw = 1'b1; end
            K_LOAD:  begin d.imm = imm_i; d.srcb = 1'b1; d.mrd = 1'b1; d.regw = 1'b1; end
            K_STORE: begin d.imm = imm_s; d.srcb = 1'b1; d.mwr = 1'b1; end
            K_BR:    begin d.alu = 4'd1; d.flag = ins[14:12]; d.imm = imm_b; d.br = 1'b1; end
            K_JAL:   begin d.imm = imm_j; d.srca = 1'b1; d.srcb = 1'b1; d.jmp = 1'b1; d.regw = 1'b1; end
            K_JALR:  begin d.imm = imm_i; d.srcb = 1'b1; d.jmp = 1'b1; d.regw = 1'b1; end
            default: begin
                d.regw = 1'b1;
                d.srcb = imm_form;
                case (k)
                    K_SUB:   d.alu = 4'd1;
                    K_SLL:   d.alu = 4'd2;
                    K_SLT:   begin d.alu = 4'd1; d.flag = 3'b100; d.setf = 1'b1; end
                    K_SLTU:  begin d.alu = 4'd1; d.flag = 3'b110; d.setf = 1'b1; end
                    K_XOR:   d.alu = 4'd3;
                    K_SRL:   d.alu = 4'd4;
                    K_SRA:   d.alu = 4'd5;
                    K_OR:    d.alu = 4'd6;
                    K_AND:   d.alu = 4'd7;
                    default: d.alu = 4'd0;
                endcase
                if (imm_form) d.imm = (k inside {K_SLL, K_SRL, K_SRA}) ? 32'(ins[24:20]) : imm_i;
            end
        endcase
        return d;
    endfunction

    // Handshake model: decides at each edge what the stage will hold next.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_valid = 1'b0;
                exp_q.delete();
            end else begin
                logic acc;
                acc = in_valid && (!m_valid || in_ready) && !in_flush;
                if (in_flush && m_valid && !in_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (acc) exp_q.push_back(model(in_instr, in_pc));
                if (in_flush)      m_valid = 1'b0;
                else if (acc)      m_valid = 1'b1;
                else if (in_ready) m_valid = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                check("valid", 96'(Valid_o), 96'(m_valid));
                check("instr_ready", 96'(InstrReady_o), 96'(!m_valid || in_ready));
                if (m_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL scoreboard: got output with empty queue at %0t", $time);
                    end else begin
                        check("decode", 96'(dut_out()), 96'(exp_q[0]));
                        if (in_ready) begin
                            $display("xfer pc=%h alu=%h flag=%h imm=%h ill=%b", Pc_o, ALUCtrl_o,
                                     Flagsel_o, Imm_o, Illegal_o);
                            void'(exp_q.pop_front());
                        end
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic rdy, input logic fl);
        in_valid = v;
        in_instr = ins;
        in_pc    = pc;
        in_ready = rdy;
        in_flush = fl;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [9];
        logic [31:0] ins;
        int          sel;
        ops = '{7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111, 7'b0000011,
                7'b0100011, 7'b1100011, 7'b1101111, 7'b1100111};
        ins = $urandom;
        sel = $urandom_range(0, 9);
        if (sel < 9) ins[6:0] = ops[sel];
        case ($urandom_range(0, 3))
            0:       ins[31:25] = 7'h00;
            1:       ins[31:25] = 7'h20;
            default: ins[31:25] = 7'($urandom);
        endcase
        return ins;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", 96'({Valid_o, dut_out()}), 96'(0));
        check("reset_ready", 96'(InstrReady_o), 96'(1));
        rst_n = 1'b1;

        drive(1'b1, 32'h002081B3, 32'h0000_1000, 1'b1, 1'b0);
        drive(1'b1, 32'h402081B3, 32'h0000_1004, 1'b1, 1'b0);
        drive(1'b1, 32'h0020C463, 32'h0000_1008, 1'b1, 1'b0);
        drive(1'b1, 32'h123452B7, 32'h0000_100C, 1'b1, 1'b0);
        drive(1'b1, 32'h4030D093, 32'h0000_1010, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        drive(1'b1, 32'h002081B3, 32'h0000_2000, 1'b1, 1'b0);
        repeat (3) drive(1'b1, 32'h0020C463, 32'h0000_2004, 1'b0, 1'b0);
        drive(1'b1, 32'h0020C463, 32'h0000_2004, 1'b1, 1'b0);
        drive(1'b1, 32'h123452B7, 32'h0000_2008, 1'b1, 1'b1);
        drive(1'b1, 32'h0000007F, 32'h0000_200C, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        for (int i = 0; i < 3000; i++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom & 32'hFFFF_FFFC,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0);
        end

        drive(1'b1, 32'h123452B7, 32'h0000_3000, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", 96'({Valid_o, dut_out()}), 96'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h0000_4000, 1'b1, 1'b0);
        repeat (3) drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
